// File: rtl/infer_seq_ctrl.sv
// Inference sequencer: start -> pixel run -> serial argmax -> UART send.
// Define INFER_SEQ_TIMEOUT_EN to build the RUN/SEND watchdog.
module infer_seq_ctrl #(
  parameter int IMG_PIXELS  = 784,
  parameter int NUM_CLASS   = 10,
  parameter int SCORE_W     = 8,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_req,
  input  logic                         pix_vld,
  input  logic [NUM_CLASS*SCORE_W-1:0] net_dout,
  input  logic                         net_dout_vld,
  input  logic                         net_dout_end,
  input  logic                         tx_ready,
  output logic                         img_start,
  output logic                         busy,
  output logic                         tx_start,
  output logic [3:0]                   tx_class,
  output logic                         result_vld,
  output logic [3:0]                   result_class,
  output logic                         err,
  output logic [1:0]                   err_code
);

  localparam int CW = $clog2(IMG_PIXELS + 2);
  localparam logic [CW-1:0] PIX_N   = CW'(IMG_PIXELS);
  localparam logic [CW-1:0] PIX_SAT = CW'(IMG_PIXELS + 1);
  localparam logic [3:0]    LAST    = 4'(NUM_CLASS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ARGMAX,
    SEND
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]                cnt, cnt_n;
  logic [NUM_CLASS*SCORE_W-1:0] score, score_n;
  logic signed [SCORE_W-1:0]    lane [NUM_CLASS];
  logic signed [SCORE_W-1:0]    cur, best;
  logic [3:0]                   idx, best_idx;
  logic                         take;
  logic                         timeout;

  assign busy = (state != IDLE);

  always_comb begin
    for (int i = 0; i < NUM_CLASS; i++) begin
      lane[i] = score[i*SCORE_W +: SCORE_W];
    end
  end

  assign cur  = lane[idx];
  assign take = (idx == 4'd0) || (cur > best);

  // Same-cycle valid/end: the evaluation sees this cycle's beat and data.
  always_comb begin
    score_n = net_dout_vld ? net_dout : score;
    cnt_n   = cnt;
    if (pix_vld && (cnt != PIX_SAT)) begin
      cnt_n = cnt + 1'b1;
    end
  end

`ifdef INFER_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  logic [WW-1:0] wd;
  logic          wd_on;

  assign wd_on   = (state == RUN) || (state == SEND);
  assign timeout = wd_on && (wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (!wd_on) begin
      wd <= '0;
    end else begin
      wd <= wd + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start_req) state_n = RUN;
      end
      RUN: begin
        if (net_dout_end) begin
          state_n = (cnt_n == PIX_N) ? ARGMAX : IDLE;
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      ARGMAX: begin
        if (idx == LAST) state_n = SEND;
      end
      SEND: begin
        if (tx_ready || timeout) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_start    <= 1'b0;
      tx_start     <= 1'b0;
      tx_class     <= '0;
      result_vld   <= 1'b0;
      result_class <= '0;
      err          <= 1'b0;
      err_code     <= '0;
      cnt          <= '0;
      score        <= '0;
      idx          <= '0;
      best         <= '0;
      best_idx     <= '0;
    end else begin
      img_start  <= 1'b0;
      tx_start   <= 1'b0;
      result_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_req) begin
            img_start <= 1'b1;
            cnt       <= '0;
            err       <= 1'b0;
            err_code  <= 2'b00;
          end
        end
        RUN: begin
          cnt   <= cnt_n;
          score <= score_n;
          idx   <= '0;
          if (net_dout_end) begin
            if (cnt_n < PIX_N) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end else if (cnt_n > PIX_N) begin
              err      <= 1'b1;
              err_code <= 2'b11;
            end
          end else if (timeout) begin
            err      <= 1'b1;
            err_code <= 2'b10;
          end
        end
        ARGMAX: begin
          idx <= idx + 1'b1;
          if (take) begin
            best     <= cur;
            best_idx <= idx;
          end
          if (idx == LAST) begin
            result_vld   <= 1'b1;
            result_class <= take ? idx : best_idx;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            tx_class <= result_class;
          end else if (timeout) begin
            err      <= 1'b1;
            err_code <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_infer_seq_ctrl.sv
// Randomized bench for infer_seq_ctrl against a frame-level reference model.
// Builds with or without INFER_SEQ_TIMEOUT_EN.
module tb_infer_seq_ctrl;

  localparam int NC = 10;
  localparam int SW = 8;
  localparam int TO = 100;
`ifdef INFER_SEQ_TIMEOUT_EN
  localparam int NPIX  = 64;
  localparam bit DENSE = 1'b1;
`else
  localparam int NPIX  = 784;
  localparam bit DENSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_req = 1'b0;
  logic pix_vld = 1'b0;
  logic net_dout_vld = 1'b0;
  logic net_dout_end = 1'b0;
  logic tx_ready = 1'b0;
  logic [NC*SW-1:0] net_dout = '0;
  logic img_start, busy, tx_start, result_vld, err;
  logic [3:0] tx_class, result_class;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;
  int rv_cnt = 0;
  int ts_cnt = 0;
  int is_cnt = 0;

  infer_seq_ctrl #(
    .IMG_PIXELS (NPIX),
    .NUM_CLASS  (NC),
    .SCORE_W    (SW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_req   (start_req),
    .pix_vld     (pix_vld),
    .net_dout    (net_dout),
    .net_dout_vld(net_dout_vld),
    .net_dout_end(net_dout_end),
    .tx_ready    (tx_ready),
    .img_start   (img_start),
    .busy        (busy),
    .tx_start    (tx_start),
    .tx_class    (tx_class),
    .result_vld  (result_vld),
    .result_class(result_class),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rv_cnt += int'(result_vld);
    ts_cnt += int'(tx_start);
    is_cnt += int'(img_start);
  endtask

  function automatic logic [NC*SW-1:0] rnd_bus();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[NC*SW-1:0];
  endfunction

  function automatic logic [NC*SW-1:0] pack(input int sc[NC]);
    logic [NC*SW-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i*SW +: SW] = SW'(sc[i]);
    return v;
  endfunction

  // Reference: first index holding the largest value.
  function automatic int argmax(input int sc[NC]);
    int b;
    b = 0;
    for (int i = 1; i < NC; i++) if (sc[i] > sc[b]) b = i;
    return b;
  endfunction

  task automatic junk();
    pix_vld      = 1'($urandom_range(0, 1));
    net_dout_vld = 1'($urandom_range(0, 1));
    net_dout_end = 1'($urandom_range(0, 1));
    net_dout     = rnd_bus();
  endtask

  task automatic quiet();
    pix_vld      = 1'b0;
    net_dout_vld = 1'b0;
    net_dout_end = 1'b0;
    start_req    = 1'b0;
  endtask

  task automatic start_stream(input int npix, input bit poke);
    int sent;
    sent   = 0;
    is_cnt = 0;
    quiet();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    check("img_start", img_start, 1);
    check("busy_run", busy, 1);
    check("err_clr", err, 0);
    check("code_clr", err_code, 0);
    while (sent < npix) begin
      pix_vld      = DENSE || ($urandom_range(0, 3) != 0);
      net_dout_vld = ($urandom_range(0, 7) == 0);
      net_dout     = rnd_bus();
      start_req    = poke && (sent == npix / 2);
      if (pix_vld) sent++;
      step();
    end
    quiet();
    if (poke) check("no_reimg", is_cnt, 1);
  endtask

  task automatic end_frame(input int sc[NC], input bit early);
    if (early) begin
      net_dout_vld = 1'b1;
      net_dout     = pack(sc);
      step();
      net_dout_vld = 1'b0;
      net_dout     = rnd_bus();
    end else begin
      net_dout_vld = 1'b1;
      net_dout     = pack(sc);
    end
    net_dout_end = 1'b1;
    check("busy_pre_end", busy, 1);
    rv_cnt = 0;
    ts_cnt = 0;
    step();
    quiet();
  endtask

  task automatic frame(input int npix, input int sc[NC], input int wait_cyc,
                       input bit early, input bit poke);
    int exp_cls, k;
    exp_cls  = argmax(sc);
    tx_ready = (wait_cyc == 0);
    start_stream(npix, poke);
    end_frame(sc, early);
    if (npix != NPIX) begin
      check("err", err, 1);
      check("err_code", err_code, (npix < NPIX) ? 1 : 3);
      check("busy_drop", busy, 0);
      for (int i = 0; i < 15; i++) begin
        junk();
        step();
      end
      quiet();
      check("no_result", rv_cnt, 0);
      check("no_tx", ts_cnt, 0);
      return;
    end
    k = 0;
    while (!result_vld && k < 40) begin
      junk();
      step();
      k++;
    end
    quiet();
    check("latency", k, NC);
    check("result_class", result_class, exp_cls);
    check("err_ok", err, 0);
    check("busy_send", busy, 1);
    for (int w = 0; w < wait_cyc; w++) begin
      tx_ready = 1'b0;
      junk();
      step();
    end
    quiet();
    check("tx_hold", ts_cnt, 0);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("tx_start", tx_start, 1);
    check("tx_class", tx_class, exp_cls);
    check("busy_idle", busy, 0);
    step();
    step();
    check("tx_once", ts_cnt, 1);
    check("rv_once", rv_cnt, 1);
    check("class_held", result_class, exp_cls);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rst_outs", {img_start, busy, tx_start, result_vld, err,
                       err_code, tx_class, result_class}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void rand_scores(output int sc[NC], input bit narrow);
    for (int i = 0; i < NC; i++) begin
      sc[i] = narrow ? ($urandom_range(0, 6) - 3) : ($urandom_range(0, 255) - 128);
    end
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int sc[NC];
    int np;

    #2 rst_n = 1'b0;
    #1;
    check("reset_state", {img_start, busy, tx_start, result_vld, err,
                          err_code, tx_class, result_class}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    sc = '{3, -5, 7, 7, 0, 0, 0, 0, 0, 0};
    frame(NPIX, sc, 0, 1'b0, 1'b0);

    // Reset while comparing scores, then restart on the first edge.
    rand_scores(sc, 1'b0);
    tx_ready = 1'b0;
    start_stream(NPIX, 1'b0);
    end_frame(sc, 1'b0);
    repeat (4) step();
    check("busy_argmax", busy, 1);
    do_reset();
    sc = '{-1, -1, -1, -1, -1, 4, -1, -1, -1, -1};
    frame(NPIX, sc, 0, 1'b0, 1'b0);

    sc = '{3, -5, 7, 7, 0, 0, 0, 0, 0, 0};
    frame(NPIX - 1, sc, 0, 1'b0, 1'b0);
    frame(NPIX + 1, sc, 0, 1'b0, 1'b0);
    frame(NPIX + 2, sc, 0, 1'b0, 1'b0);

    rand_scores(sc, 1'b0);
    frame(NPIX, sc, 2, 1'b0, 1'b1);
    rand_scores(sc, 1'b1);
    frame(NPIX, sc, 50, 1'b1, 1'b0);

    sc = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    frame(NPIX, sc, 1, 1'b0, 1'b0);
    sc = '{0, 0, 0, 0, 0, 0, 0, 0, -128, 127};
    frame(NPIX, sc, 0, 1'b1, 1'b0);

`ifdef INFER_SEQ_TIMEOUT_EN
    quiet();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    repeat (TO - 1) step();
    check("to_pre_err", err, 0);
    check("to_pre_busy", busy, 1);
    step();
    check("to_err", err, 1);
    check("to_code", err_code, 2);
    check("to_busy", busy, 0);
`else
    quiet();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    repeat (TO + 50) step();
    check("wait_busy", busy, 1);
    check("wait_err", err, 0);
    do_reset();
`endif

    for (int n = 0; n < 6; n++) begin
      rand_scores(sc, 1'($urandom_range(0, 1)));
      case ($urandom_range(0, 5))
        0: np = NPIX - 1 - int'($urandom_range(0, 3));
        1: np = NPIX + 1 + int'($urandom_range(0, 3));
        default: np = NPIX;
      endcase
      frame(np, sc, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/infer_seq_ctrl.md
INFER_SEQ_CTRL -- requirements
Module: infer_seq_ctrl

Interface
REQ-001 SHALL have parameter IMG_PIXELS, default 784: pixel beats expected per inference.
REQ-002 SHALL have parameter NUM_CLASS, default 10: class scores in the network output.
REQ-003 SHALL have parameter SCORE_W, default 8: width of each signed score.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 2000000: watchdog limit in cycles.
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port start_req, input, 1: one-cycle start pulse from the key block.
REQ-008 SHALL have port pix_vld, input, 1: image-stream beat into the network.
REQ-009 SHALL have port net_dout, input, NUM_CLASS*SCORE_W: packed scores, class 0 in the LSBs.
REQ-010 SHALL have port net_dout_vld, input, 1: net_dout is valid.
REQ-011 SHALL have port net_dout_end, input, 1: the network has finished the frame.
REQ-012 SHALL have port tx_ready, input, 1: the UART sender can accept a result.
REQ-013 SHALL have port img_start, output, 1: one-cycle start pulse to the image source.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port tx_start, output, 1: one-cycle send pulse.
REQ-016 SHALL have port tx_class, output, 4: class index sent.
REQ-017 SHALL have port result_vld, output, 1: one-cycle pulse when argmax completes.
REQ-018 SHALL have port result_class, output, 4: winning class, held until the next result.
REQ-019 SHALL have port err, output, 1: sticky error flag, cleared by the next accepted start.
REQ-020 SHALL have port err_code, output, 2: 00 none, 01 pixel underrun, 10 timeout, 11 pixel overrun.

Function
REQ-021 SHALL implement the states IDLE, RUN, ARGMAX and SEND.
REQ-022 IDLE, start_req=1: SHALL pulse img_start the next cycle, clear the pixel counter, watchdog, err and err_code, and enter RUN.
REQ-023 start_req SHALL be ignored outside IDLE, with no pulse and no state change.
REQ-024 RUN: each pix_vld SHALL increment the pixel counter, which saturates at IMG_PIXELS+1.
REQ-025 RUN: on net_dout_vld, SHALL latch net_dout into the score register, with the last latch winning.
REQ-026 When net_dout_vld and net_dout_end occur in the same cycle, SHALL latch that cycle's data before evaluating.
REQ-027 RUN, net_dout_end, count==IMG_PIXELS: SHALL enter ARGMAX.
REQ-028 RUN, net_dout_end, count<IMG_PIXELS: SHALL set err, set code 01, and go to IDLE.
REQ-029 RUN, net_dout_end, count>IMG_PIXELS: SHALL set err, set code 11, and go to IDLE.
REQ-030 ARGMAX SHALL compare one signed score per cycle, indices 0..NUM_CLASS-1, keeping the strict maximum so a tie goes to the lowest index.
REQ-031 With net_dout_end at cycle N, result_vld SHALL pulse at N+NUM_CLASS+1 and the state SHALL become SEND.
REQ-032 SEND SHALL wait for tx_ready=1, then pulse tx_start for one cycle with tx_class=result_class and return to IDLE.
REQ-033 pix_vld, net_dout_vld and net_dout_end SHALL be ignored outside RUN.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and drive all outputs, counters and the score register to 0, including during RUN, ARGMAX or SEND.
REQ-035 The first start_req SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-036 With INFER_SEQ_TIMEOUT_EN defined, the watchdog SHALL count cycles in RUN and SEND; on reaching TIMEOUT_CYC it SHALL set err, set code 10, and go to IDLE.
REQ-037 With INFER_SEQ_TIMEOUT_EN undefined, there SHALL be no watchdog logic, the controller waits indefinitely, and code 10 is never produced.

Verification
REQ-038 Bench SHALL drive 784 pixels with scores 3,-5,7,7,0,... and tx_ready=1 -> required: result_class=2, result_vld pulses 11 cycles after end, and tx_start pulses once with tx_class=2.
REQ-039 Bench SHALL drive 783 pixels then end -> required: err=1, err_code=01, no result_vld, and busy falling the next cycle.
REQ-040 Bench SHALL pulse start_req during RUN -> required: no second img_start and the pixel count unchanged.
REQ-041 Bench SHALL assert rst_n low mid-ARGMAX -> required: all outputs 0 immediately and a fresh start works.
REQ-042 Bench SHALL enable INFER_SEQ_TIMEOUT_EN with TIMEOUT_CYC=100 and no end -> required: err_code=10 after 100 cycles in RUN; with the macro undefined, busy stays high.
REQ-043 Bench SHALL hold tx_ready=0 for 50 cycles in SEND -> required: tx_start pulses exactly once, on the cycle after tx_ready rises.
